// File: rtl/global_avg_pool_stream.sv
// Streaming global average pooling stage.
// Accumulates one channel-interleaved frame (pixel-major, channel-minor) into
// per-channel sums, then drains round(sum * RECIP / 65536), saturated to
// DATA_WIDTH, as a single AXI-Stream vector of NUM_CHANNELS beats.
module global_avg_pool_stream #(
  parameter int          DATA_WIDTH   = 16,
  parameter int          NUM_CHANNELS = 960,
  parameter int          NUM_PIXELS   = 49,
  parameter int          ACC_WIDTH    = 24,
  parameter int unsigned RECIP        = 1337
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  frame_error,
  output logic                  processing_done
);

  localparam int CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int PX_W   = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
  localparam int PROD_W = ACC_WIDTH + 17;

  localparam logic [CH_W-1:0]          LAST_CH  = CH_W'(NUM_CHANNELS - 1);
  localparam logic [PX_W-1:0]          LAST_PX  = PX_W'(NUM_PIXELS - 1);
  localparam logic signed [16:0]       RECIP_S  = {1'b0, 16'(RECIP)};
  localparam logic signed [PROD_W-1:0] HALF_LSB = PROD_W'(32768);
  localparam logic signed [PROD_W-1:0] OUT_MAX  = PROD_W'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PROD_W-1:0] OUT_MIN  = PROD_W'(-(2 ** (DATA_WIDTH - 1)));

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_DRAIN
  } state_e;

  state_e                         state_q, state_d;
  logic [CH_W-1:0]                ch_q, ch_d;
  logic [PX_W-1:0]                px_q, px_d;
  logic                           s_ready_q, s_ready_d;
  logic [CH_W-1:0]                rd_ch_q, rd_ch_d;
  logic                           issued_all_q, issued_all_d;
  logic                           p1_valid_q, p1_valid_d;
  logic signed [ACC_WIDTH-1:0]    p1_acc_q, p1_acc_d;
  logic                           p1_last_q, p1_last_d;
  logic                           m_valid_q, m_valid_d;
  logic [DATA_WIDTH-1:0]          m_data_q, m_data_d;
  logic                           m_last_q, m_last_d;

  logic signed [ACC_WIDTH-1:0]    acc_mem [NUM_CHANNELS];

  logic                           in_fire;
  logic                           last_ch;
  logic                           last_beat;
  logic                           out_fire;
  logic                           out_adv;
  logic                           issue;
  logic signed [ACC_WIDTH-1:0]    sample_ext;
  logic signed [PROD_W-1:0]       prod;
  logic signed [PROD_W-1:0]       rounded;
  logic signed [PROD_W-1:0]       shifted;
  logic [DATA_WIDTH-1:0]          sat_value;

  assign in_fire    = s_axis_tvalid && s_ready_q;
  assign last_ch    = (ch_q == LAST_CH);
  assign last_beat  = last_ch && (px_q == LAST_PX);
  assign out_fire   = m_valid_q && m_axis_tready;
  assign out_adv    = !m_valid_q || m_axis_tready;
  assign issue      = (state_q == ST_DRAIN) && !issued_all_q && (!p1_valid_q || out_adv);
  assign sample_ext = ACC_WIDTH'($signed(s_axis_tdata));

  assign s_axis_tready   = s_ready_q;
  assign m_axis_tvalid   = m_valid_q;
  assign m_axis_tdata    = m_data_q;
  assign m_axis_tlast    = m_last_q;
  assign frame_error     = in_fire && (s_axis_tlast != last_beat);
  assign processing_done = out_fire && m_last_q;

  // Scale the drained sum by the reciprocal, round half toward +inf, saturate.
  always_comb begin
    prod    = PROD_W'(p1_acc_q) * PROD_W'(RECIP_S);
    rounded = prod + HALF_LSB;
    shifted = rounded >>> 16;
    if (shifted > OUT_MAX) begin
      sat_value = OUT_MAX[DATA_WIDTH-1:0];
    end else if (shifted < OUT_MIN) begin
      sat_value = OUT_MIN[DATA_WIDTH-1:0];
    end else begin
      sat_value = shifted[DATA_WIDTH-1:0];
    end
  end

  // Accumulate: pixel 0 overwrites, later pixels add with ACC_WIDTH wrap.
  // The read and write of an entry happen in the same cycle, so back-to-back
  // beats to one channel (NUM_CHANNELS == 1) always see the updated sum.
  // NOTE: the accumulator memory is deliberately not reset; pixel 0 of every
  // frame overwrites each entry, so stale contents never reach the output.
  always_ff @(posedge clk) begin
    if (rst_n && in_fire) begin
      if (px_q == '0) begin
        acc_mem[ch_q] <= sample_ext;
      end else begin
        acc_mem[ch_q] <= acc_mem[ch_q] + sample_ext;
      end
    end
  end

  // Next-state logic for the FSM, counters and two-stage drain pipeline.
  always_comb begin
    // NOTE: every _d signal takes its _q value first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    ch_d         = ch_q;
    px_d         = px_q;
    rd_ch_d      = rd_ch_q;
    issued_all_d = issued_all_q;
    p1_valid_d   = p1_valid_q;
    p1_acc_d     = p1_acc_q;
    p1_last_d    = p1_last_q;
    m_valid_d    = m_valid_q;
    m_data_d     = m_data_q;
    m_last_d     = m_last_q;

    // Input side: counters alone decide where the frame ends.
    if (in_fire) begin
      if (last_beat) begin
        state_d      = ST_DRAIN;
        ch_d         = '0;
        px_d         = '0;
        rd_ch_d      = '0;
        issued_all_d = 1'b0;
      end else begin
        state_d = ST_ACCUM;
        if (last_ch) begin
          ch_d = '0;
          px_d = px_q + PX_W'(1);
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
    end

    // Output register refills whenever it is empty or being consumed.
    if (out_adv) begin
      m_valid_d  = p1_valid_q;
      p1_valid_d = 1'b0;
      if (p1_valid_q) begin
        m_data_d = sat_value;
        m_last_d = p1_last_q;
      end else begin
        m_last_d = 1'b0;
      end
    end

    // Read stage fetches the next channel sum in order.
    if (issue) begin
      p1_valid_d   = 1'b1;
      p1_acc_d     = acc_mem[rd_ch_q];
      p1_last_d    = (rd_ch_q == LAST_CH);
      issued_all_d = (rd_ch_q == LAST_CH);
      rd_ch_d      = (rd_ch_q == LAST_CH) ? '0 : rd_ch_q + CH_W'(1);
    end

    if (state_q == ST_DRAIN && out_fire && m_last_q) begin
      state_d = ST_IDLE;
    end

    // enable only matters while idle; ACCUM always accepts, DRAIN never does.
    s_ready_d = ((state_d == ST_IDLE) && enable) || (state_d == ST_ACCUM);
  end

  // State registers with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of all others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ch_q         <= '0;
      px_q         <= '0;
      s_ready_q    <= 1'b0;
      rd_ch_q      <= '0;
      issued_all_q <= 1'b0;
      p1_valid_q   <= 1'b0;
      p1_acc_q     <= '0;
      p1_last_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      m_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      px_q         <= px_d;
      s_ready_q    <= s_ready_d;
      rd_ch_q      <= rd_ch_d;
      issued_all_q <= issued_all_d;
      p1_valid_q   <= p1_valid_d;
      p1_acc_q     <= p1_acc_d;
      p1_last_q    <= p1_last_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      m_last_q     <= m_last_d;
    end
  end

endmodule

// File: tb/tb_global_avg_pool_stream.sv
// Self-checking bench for global_avg_pool_stream: a 4x4 instance for the
// directed and random frame tests, and a 1-channel instance with an oversized
// reciprocal to reach saturation and same-channel back-to-back accumulation.
module tb_global_avg_pool_stream;

  localparam int DW  = 16;
  localparam int NC  = 4;
  localparam int NP  = 4;
  localparam int NB  = NC * NP;
  localparam int RCP = 16384;
  localparam int XRCP = 65535;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic          frame_error;
  logic          processing_done;

  logic [DW-1:0] x_tdata = '0;
  logic          x_tvalid = 1'b0;
  logic          x_tready;
  logic          x_tlast = 1'b0;
  logic [DW-1:0] x_mdata;
  logic          x_mvalid;
  logic          x_mlast;
  logic          x_ferr;
  logic          x_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int smp [NB];
  bit tl [NB];
  int exp_v [NC];

  global_avg_pool_stream #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .NUM_PIXELS(NP), .ACC_WIDTH(24), .RECIP(RCP)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .frame_error(frame_error), .processing_done(processing_done)
  );

  global_avg_pool_stream #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(1), .NUM_PIXELS(2), .ACC_WIDTH(24), .RECIP(XRCP)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .enable(1'b1),
    .s_axis_tdata(x_tdata), .s_axis_tvalid(x_tvalid),
    .s_axis_tready(x_tready), .s_axis_tlast(x_tlast),
    .m_axis_tdata(x_mdata), .m_axis_tvalid(x_mvalid),
    .m_axis_tready(1'b1), .m_axis_tlast(x_mlast),
    .frame_error(x_ferr), .processing_done(x_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: mean via the reciprocal, round half up, clamp to DW bits.
  function automatic longint avg_of(input longint sum, input longint recip);
    longint r;
    r = (sum * recip + 32768) >>> 16;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  // kind 0: 10c+p, 1: all -3, 2: random full range. tlast on the final beat.
  task automatic set_frame(input int kind);
    for (int k = 0; k < NB; k++) begin
      case (kind)
        0:       smp[k] = 10 * (k % NC) + (k / NC);
        1:       smp[k] = -3;
        default: smp[k] = int'($urandom_range(65535)) - 32768;
      endcase
      tl[k] = (k == NB - 1);
    end
  endtask

  task automatic build_expected();
    for (int c = 0; c < NC; c++) begin
      longint sum = 0;
      for (int p = 0; p < NP; p++) sum += smp[p * NC + c];
      exp_v[c] = int'(avg_of(sum, RCP));
    end
  endtask

  // Drive the first n beats of the frame; entered and left at posedge+1.
  task automatic send_frame(input int n, input int gap_pct);
    for (int k = 0; k < n; k++) begin
      bit acc = 0;
      int w = 0;
      while ($urandom_range(99) < gap_pct) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(smp[k]);
      s_axis_tlast  = tl[k];
      while (!acc && w < 200) begin
        @(negedge clk);
        if (s_axis_tready) begin
          acc = 1;
          check("frame_error", frame_error, tl[k] != (k == NB - 1));
        end
        @(posedge clk); #1;
        w++;
      end
      if (!acc) check("send_timeout", k, -1);
      last_acc = cyc;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0 repeating, 2: random.
  task automatic collect(input int mode);
    int got = 0;
    int waited = 0;
    int pat = 0;
    int first_hs = -1;
    bit seen_v = 0;
    bit pend = 0;
    logic [DW-1:0] held = '0;
    while (got < NC && waited < 500) begin
      case (mode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = (pat % 3 == 0);
        default: m_axis_tready = 1'($urandom_range(1));
      endcase
      pat++;
      @(negedge clk);
      waited++;
      if (pend) begin
        check("hold_valid", m_axis_tvalid, 1);
        check("hold_data", $signed(m_axis_tdata), $signed(held));
      end
      if (m_axis_tvalid) begin
        if (!seen_v) begin
          seen_v = 1;
          check("latency", cyc, last_acc + 2);
        end
        check("s_ready_in_drain", s_axis_tready, 0);
        if (m_axis_tready) begin
          check("out_data", $signed(m_axis_tdata), exp_v[got]);
          check("out_last", m_axis_tlast, got == NC - 1);
          check("done", processing_done, got == NC - 1);
          if (mode == 0) begin
            if (first_hs < 0) first_hs = cyc;
            else check("contiguous", cyc, first_hs + got);
          end
          got++;
          pend = 0;
        end else begin
          pend = 1;
          held = m_axis_tdata;
        end
      end else begin
        check("done_idle", processing_done, 0);
      end
      @(posedge clk); #1;
    end
    if (got < NC) check("collect_timeout", got, NC);
    m_axis_tready = 1'b0;
    @(negedge clk);
    check("valid_cleared", m_axis_tvalid, 0);
    check("ready_after_done", s_axis_tready, enable);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int mode, input int gap_pct);
    build_expected();
    fork
      send_frame(NB, gap_pct);
      collect(mode);
    join
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    check("rst_s_ready", s_axis_tready, 0);
    check("rst_m_valid", m_axis_tvalid, 0);
    check("rst_m_last", m_axis_tlast, 0);
    check("rst_m_data", m_axis_tdata, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_done", processing_done, 0);
    rst_n = 1'b1;
  endtask

  // One 2-beat frame into the 1-channel instance.
  task automatic x_frame(input int a, input int b);
    int w = 0;
    longint expv = avg_of(longint'(a) + longint'(b), XRCP);
    for (int k = 0; k < 2; k++) begin
      bit acc = 0;
      x_tvalid = 1'b1;
      x_tdata  = DW'((k == 0) ? a : b);
      x_tlast  = (k == 1);
      w = 0;
      while (!acc && w < 50) begin
        @(negedge clk);
        if (x_tready) begin
          acc = 1;
          check("sat_frame_error", x_ferr, 0);
        end
        @(posedge clk); #1;
        w++;
      end
      if (!acc) check("sat_send_timeout", k, -1);
    end
    x_tvalid = 1'b0;
    x_tlast  = 1'b0;
    w = 0;
    @(negedge clk);
    while (!x_mvalid && w < 50) begin
      @(posedge clk); #1;
      @(negedge clk);
      w++;
    end
    check("sat_out", $signed(x_mdata), expv);
    check("sat_last", x_mlast, 1);
    check("sat_done", x_done, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_s_ready", s_axis_tready, 0);
    check("reset_m_valid", m_axis_tvalid, 0);
    check("reset_m_last", m_axis_tlast, 0);
    check("reset_m_data", m_axis_tdata, 0);
    check("reset_frame_error", frame_error, 0);
    check("reset_done", processing_done, 0);
    rst_n  = 1'b1;
    enable = 1'b1;
    @(posedge clk); #1;

    // Ramp frame, full throughput; then constant negative frame.
    set_frame(0);
    run_frame(0, 0);
    set_frame(1);
    run_frame(0, 0);

    // Backpressure 1,0,0 and an immediate follow-on frame.
    set_frame(0);
    run_frame(1, 0);
    run_frame(0, 0);

    // Misplaced tlast: early on beat 9, missing on beat 15.
    set_frame(0);
    tl[9]  = 1'b1;
    tl[15] = 1'b0;
    run_frame(0, 0);

    // Abort after beat 7 with junk data, then a clean frame.
    for (int k = 0; k < NB; k++) begin
      smp[k] = 12345 - k * 999;
      tl[k]  = 1'b0;
    end
    send_frame(8, 0);
    pulse_reset();
    @(posedge clk); #1;
    set_frame(0);
    run_frame(0, 0);

    // Abort while a drained value is stalled, then a clean frame.
    set_frame(2);
    send_frame(NB, 0);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    check("stalled_valid", m_axis_tvalid, 1);
    @(posedge clk); #1;
    pulse_reset();
    @(posedge clk); #1;
    set_frame(0);
    run_frame(0, 0);

    // enable low holds the block idle even with valid input.
    enable = 1'b0;
    @(posedge clk); #1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = DW'(777);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ready_low", s_axis_tready, 0);
      check("idle_no_valid", m_axis_tvalid, 0);
      @(posedge clk); #1;
    end
    enable = 1'b1;
    s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("ready_after_enable", s_axis_tready, 1);
    @(posedge clk); #1;
    set_frame(0);
    run_frame(0, 0);

    // Random frames with random gaps and random backpressure.
    for (int f = 0; f < 6; f++) begin
      set_frame(2);
      run_frame(2, 30);
    end

    // Saturation and single-channel accumulation.
    x_frame(32767, 32767);
    x_frame(-32768, -32768);
    x_frame(100, 50);
    x_frame(1, 0);
    x_frame(-1, 0);
    for (int i = 0; i < 4; i++) begin
      x_frame(int'($urandom_range(65535)) - 32768, int'($urandom_range(65535)) - 32768);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
